mult_share_arbiter: RTL and testbench

- Shares one 6x6 unsigned shift-add multiplier engine between two requesters.
- Arbitrates round-robin, accepts one operand pair per job with a valid/ready handshake, and sequences the engine one partial product per clock.
- Returns the product with the winning requester's ID.
- Sits between the operand producers and the multiplier datapath; only this block drives the engine's start and operand inputs.

---
 rtl/mult_share_pkg.sv | 17 +
 rtl/shift_add_core.sv | 66 ++++++
 rtl/mult_share_arbiter.sv | 100 ++++++++++
 tb/tb_mult_share_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types for the two-requester multiplier arbiter.
// Optional build macro MULT_EARLY_TERM_EN (used by shift_add_core) enables
// early termination once no set multiplicand bits remain.
package mult_share_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of a requester; two requesters share the engine.
  typedef logic req_id_t;

endpackage

// File: rtl/shift_add_core.sv
// Unsigned shift-add multiplier datapath: one partial product per clock.
// A start pulse loads a and b; done pulses on the final iteration, after
// which product holds the result until the next start.
// With MULT_EARLY_TERM_EN defined, the run ends as soon as no set bits of a
// remain above the current position; otherwise it always takes WIDTH cycles.
module shift_add_core
  import mult_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               running_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               last_iter;

  // Decide whether the current iteration is the final one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    last_iter = (count_q == CW'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
    if ((a_q >> (count_q + 1'b1)) == '0) last_iter = 1'b1;
`endif
  end

  // Counter, operand and accumulator registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous active-low, so it lives inside the clocked branch.
    if (!rst) begin
      running_q <= 1'b0;
      count_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
    end else if (start) begin
      // NOTE: sequential state uses non-blocking assignments only.
      running_q <= 1'b1;
      count_q   <= '0;
      a_q       <= a;
      b_q       <= b;
      acc_q     <= '0;
    end else if (running_q) begin
      if (a_q[count_q]) acc_q <= acc_q + ({{WIDTH{1'b0}}, b_q} << count_q);
      count_q <= count_q + 1'b1;
      if (last_iter) running_q <= 1'b0;
    end
  end

  assign busy    = running_q;
  assign done    = running_q && last_iter;
  assign product = acc_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift_add_core between two requesters.
// IDLE grants combinationally, RUN waits for the core, DONE holds the
// response until the consumer takes it. Build macro MULT_EARLY_TERM_EN
// shortens RUN for small multiplicands (handled inside shift_add_core).
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_product,
  output logic               busy
);

  state_t             state_q, state_d;
  req_id_t            rr_ptr_q, id_q, grant_id;
  logic               grant_vld;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               core_busy, core_done;
  logic [2*WIDTH-1:0] core_product;

  // Round-robin grant: the pointed-to requester first, then the other one.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr_ptr_q;
    if (rst && state_q == IDLE) begin
      if (req_valid[rr_ptr_q]) begin
        grant_vld = 1'b1;
      end else if (req_valid[~rr_ptr_q]) begin
        grant_vld = 1'b1;
        grant_id  = ~rr_ptr_q;
      end
    end
  end

  assign sel_a = grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b = grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

  shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (grant_vld),
    .a       (sel_a),
    .b       (sel_b),
    .busy    (core_busy),
    .done    (core_done),
    .product (core_product)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; RUN also falls through if the core idles without a done pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_vld) state_d = RUN;
      RUN:     if (core_done || !core_busy) state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-robin pointer and owner of the job in flight, updated at grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
    end else if (grant_vld) begin
      rr_ptr_q <= ~grant_id;
      id_q     <= grant_id;
    end
  end

  // Outputs decoded from state; the response is presented only in DONE.
  always_comb begin
    req_ready    = '0;
    busy         = (state_q != IDLE);
    resp_valid   = (state_q == DONE);
    resp_id      = 1'b0;
    resp_product = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
    if (state_q == DONE) begin
      resp_id      = id_q;
      resp_product = core_product;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter against a cycle-level job model.
module tb_mult_share_arbiter;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a, req_b;
  logic           resp_valid, resp_ready, resp_id, busy;
  logic [2*W-1:0] resp_product;

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester side: operands held until accepted.
  logic [1:0]   vld;
  logic [W-1:0] op_a [2];
  logic [W-1:0] op_b [2];

  // Model: phase 0 idle, 1 computing, 2 result waiting.
  int   m_phase, m_left, m_rr, m_id, m_prod;
  logic prev_rst;

  function automatic int job_cycles(input int a);
`ifdef MULT_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (a[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  function automatic logic [W-1:0] rand_op();
    int r = $urandom_range(9);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return W'($urandom_range(2**W - 1));
  endfunction

  task automatic present(input int i, input int a, input int b);
    vld[i]  = 1'b1;
    op_a[i] = W'(a);
    op_b[i] = W'(b);
  endtask

  // One clock: drive at negedge, check, then advance the model past the posedge.
  task automatic step(input logic rst_v, input int p_req, input int p_rsp);
    int g;
    logic [1:0] exp_ready;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      if (!vld[i] && int'($urandom_range(99)) < p_req) present(i, rand_op(), rand_op());
    rst        = rst_v;
    resp_ready = (int'($urandom_range(99)) < p_rsp);
    req_valid  = vld;
    req_a      = {op_a[1], op_a[0]};
    req_b      = {op_b[1], op_b[0]};
    #1;
    g = -1;
    if (rst_v && m_phase == 0) begin
      if (vld[m_rr])          g = m_rr;
      else if (vld[1 - m_rr]) g = 1 - m_rr;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      check("resp_product", 32'(resp_product), m_prod);
      check("resp_id", 32'(resp_id), m_id);
    end
    if (!prev_rst) begin
      check("reset_product", 32'(resp_product), 0);
      check("reset_id", 32'(resp_id), 0);
    end
    prev_rst = rst_v;
    if (!rst_v) begin
      m_phase = 0;
      m_rr    = 0;
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
          m_phase = 1;
          m_left  = job_cycles(int'(op_a[g]));
          m_id    = g;
          m_prod  = int'(op_a[g]) * int'(op_b[g]);
          m_rr    = 1 - g;
          vld[g]  = 1'b0;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (resp_ready) m_phase = 0;
      endcase
    end
  endtask

  initial begin
    vld        = '0;
    op_a[0]    = '0; op_a[1] = '0;
    op_b[0]    = '0; op_b[1] = '0;
    m_phase    = 0; m_left = 0; m_rr = 0; m_id = 0; m_prod = 0;
    prev_rst   = 1'b1;
    rst        = 1'b0;
    resp_ready = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;

    // Reset, then idle with no requests.
    repeat (2) step(1'b0, 0, 0);
    repeat (3) step(1'b1, 0, 100);

    // Single jobs, including the largest operands and a zero multiplicand.
    present(0, 6, 7);   repeat (10) step(1'b1, 0, 100);
    present(0, 63, 63); repeat (10) step(1'b1, 0, 100);
    present(1, 0, 45);  repeat (10) step(1'b1, 0, 100);
    present(1, 1, 50);  repeat (10) step(1'b1, 0, 100);

    // Contention: both requesters always valid, alternating grants.
    present(0, 5, 9);
    present(1, 12, 3);
    repeat (40) step(1'b1, 100, 100);
    repeat (10) step(1'b1, 0, 100);

    // Backpressure: result held in DONE while the other requester waits.
    present(0, 9, 11);
    present(1, 4, 4);
    repeat (14) step(1'b1, 0, 0);
    repeat (20) step(1'b1, 0, 100);

    // Reset while the core is mid-run, then a clean job.
    present(0, 5, 5);
    step(1'b1, 0, 100);
    repeat (3) step(1'b1, 0, 100);
    step(1'b0, 0, 100);
    present(0, 2, 3);
    repeat (10) step(1'b1, 0, 100);

    // Random traffic, backpressure and occasional resets.
    repeat (800)
      step(($urandom_range(99) != 0), int'($urandom_range(100)), int'($urandom_range(100)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
